// File: rtl/gshare_btb_predictor.sv
// Branch prediction unit: direct-mapped tagged BTB plus a table of saturating
// direction counters, indexed bimodally (MODE=0) or gshare-style (MODE=1).
// Lookup is combinational; updates, GHR repair and the mispredict count are
// registered.
module gshare_btb_predictor #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned CTR_W  = 2,
   parameter int unsigned GHR_W  = 6,
   parameter int unsigned MODE   = 1
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              LOOKUP_VALID,
   input  logic [ADDR_W-1:0] LOOKUP_PC,
   output logic              PRED_HIT,
   output logic              PRED_TAKEN,
   output logic [ADDR_W-1:0] PRED_TARGET,
   output logic [GHR_W-1:0]  PRED_GHR,
   input  logic              UPD_VALID,
   input  logic [ADDR_W-1:0] UPD_PC,
   input  logic [GHR_W-1:0]  UPD_GHR,
   input  logic              UPD_TAKEN,
   input  logic [ADDR_W-1:0] UPD_TARGET,
   input  logic              UPD_MISPRED,
   output logic [31:0]       MISPRED_CNT
);

   localparam int unsigned ENTRIES = 2 ** IDX_W;
   localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
   // Weakly-not-taken: MSB clear, all lower bits set.
   localparam logic [CTR_W-1:0] CtrInit = CTR_W'((2 ** (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};

   logic [ENTRIES-1:0] validQ;
   logic [TAG_W-1:0]   tagQ    [ENTRIES];
   logic [ADDR_W-1:0]  targetQ [ENTRIES];
   logic [CTR_W-1:0]   ctrQ    [ENTRIES];
   logic [GHR_W-1:0]   ghrQ, ghrD;
   logic [31:0]        mispredCntQ;

   logic [IDX_W-1:0] lkIdx, lkCidx, updIdx, updCidx;
   logic [TAG_W-1:0] lkTag, updTag;
   logic [CTR_W-1:0] ctrCur, ctrNext;
   logic             predHit, predTaken;
   logic             unusedPcBits;

   // Word-aligned PCs: the byte-offset bits carry no information.
   assign unusedPcBits = ^{LOOKUP_PC[1:0], UPD_PC[1:0]};

   function automatic logic [IDX_W-1:0] ctrIndex(input logic [IDX_W-1:0] idx,
                                                 input logic [GHR_W-1:0] ghr);
      if (MODE == 0) begin
         return idx;
      end
      return idx ^ IDX_W'(ghr);
   endfunction

   // Field extraction and counter indexing for both lookup and update paths.
   always_comb begin
      lkIdx   = LOOKUP_PC[IDX_W+1:2];
      lkTag   = LOOKUP_PC[ADDR_W-1:IDX_W+2];
      lkCidx  = ctrIndex(lkIdx, ghrQ);
      updIdx  = UPD_PC[IDX_W+1:2];
      updTag  = UPD_PC[ADDR_W-1:IDX_W+2];
      // Update uses the history captured at fetch, not the live GHR.
      updCidx = ctrIndex(updIdx, UPD_GHR);
   end

   // Combinational prediction from pre-update state.
   always_comb begin
      predHit     = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
      predTaken   = predHit && ctrQ[lkCidx][CTR_W-1];
      PRED_HIT    = predHit;
      PRED_TAKEN  = predTaken;
      PRED_TARGET = predHit ? targetQ[lkIdx] : '0;
      PRED_GHR    = ghrQ;
      MISPRED_CNT = mispredCntQ;
   end

   // Saturating counter next value for the entry being updated.
   always_comb begin
      ctrCur  = ctrQ[updCidx];
      ctrNext = ctrCur;
      if (UPD_TAKEN) begin
         if (ctrCur != CtrMax) ctrNext = ctrCur + 1'b1;
      end else begin
         if (ctrCur != '0) ctrNext = ctrCur - 1'b1;
      end
   end

   // GHR next state: mispredict repair beats speculative shift; shifting into a
   // GHR_W-wide register naturally reduces to just the new bit when GHR_W=1.
   always_comb begin
      ghrD = ghrQ;
      if (UPD_VALID && UPD_MISPRED) begin
         ghrD = (UPD_GHR << 1) | GHR_W'(UPD_TAKEN);
      end else if (LOOKUP_VALID && predHit) begin
         ghrD = (ghrQ << 1) | GHR_W'(predTaken);
      end
   end

   // BTB entries: installed/overwritten only by taken updates.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         validQ <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tagQ[i]    <= '0;
            targetQ[i] <= '0;
         end
      end else if (UPD_VALID && UPD_TAKEN) begin
         validQ[updIdx]  <= 1'b1;
         tagQ[updIdx]    <= updTag;
         targetQ[updIdx] <= UPD_TARGET;
      end
   end

   // Direction counter table.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctrQ[i] <= CtrInit;
         end
      end else if (UPD_VALID) begin
         ctrQ[updCidx] <= ctrNext;
      end
   end

   // Global history and wrapping mispredict counter.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         ghrQ        <= '0;
         mispredCntQ <= '0;
      end else begin
         ghrQ <= ghrD;
         if (UPD_VALID && UPD_MISPRED) mispredCntQ <= mispredCntQ + 32'd1;
      end
   end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares against the selected instance (0: bimodal, 1: gshare).
module tb_gshare_btb_predictor;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned IDX_W  = 6;
   localparam int unsigned CTR_W  = 2;
   localparam int unsigned GHR_W  = 6;

   typedef struct {
      string       nm;
      bit          sel;
      bit          hit;
      bit          taken;
      logic [11:0] tgt;
      logic [5:0]  ghr;
      logic [31:0] cnt;
   } exp_t;

   logic              CLK;
   logic              RSTn;
   logic              LOOKUP_VALID;
   logic [ADDR_W-1:0] LOOKUP_PC;
   logic              UPD_VALID;
   logic [ADDR_W-1:0] UPD_PC;
   logic [GHR_W-1:0]  UPD_GHR;
   logic              UPD_TAKEN;
   logic [ADDR_W-1:0] UPD_TARGET;
   logic              UPD_MISPRED;

   logic              hit0, taken0, hit1, taken1;
   logic [ADDR_W-1:0] tgt0, tgt1;
   logic [GHR_W-1:0]  ghr0, ghr1;
   logic [31:0]       cnt0, cnt1;

   exp_t expQ[$];
   exp_t e;
   bit   chkEn;
   int   nCmp;
   int   nFail;

   gshare_btb_predictor #(
      .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .MODE(0)
   ) dut0 (
      .CLK(CLK), .RSTn(RSTn), .LOOKUP_VALID(LOOKUP_VALID), .LOOKUP_PC(LOOKUP_PC),
      .PRED_HIT(hit0), .PRED_TAKEN(taken0), .PRED_TARGET(tgt0), .PRED_GHR(ghr0),
      .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_GHR(UPD_GHR), .UPD_TAKEN(UPD_TAKEN),
      .UPD_TARGET(UPD_TARGET), .UPD_MISPRED(UPD_MISPRED), .MISPRED_CNT(cnt0)
   );

   gshare_btb_predictor #(
      .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .GHR_W(GHR_W), .MODE(1)
   ) dut1 (
      .CLK(CLK), .RSTn(RSTn), .LOOKUP_VALID(LOOKUP_VALID), .LOOKUP_PC(LOOKUP_PC),
      .PRED_HIT(hit1), .PRED_TAKEN(taken1), .PRED_TARGET(tgt1), .PRED_GHR(ghr1),
      .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC), .UPD_GHR(UPD_GHR), .UPD_TAKEN(UPD_TAKEN),
      .UPD_TARGET(UPD_TARGET), .UPD_MISPRED(UPD_MISPRED), .MISPRED_CNT(cnt1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      nCmp++;
      if (act !== req) begin
         nFail++;
         $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: compares the selected instance mid-cycle whenever a check is posted.
   always @(negedge CLK) begin
      if (chkEn) begin
         if (expQ.size() == 0) begin
            nCmp++;
            nFail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
         end else begin
            e = expQ.pop_front();
            if (e.sel) begin
               cmp(e.nm, "hit", 32'(hit1), 32'(e.hit));
               cmp(e.nm, "taken", 32'(taken1), 32'(e.taken));
               cmp(e.nm, "target", 32'(tgt1), 32'(e.tgt));
               cmp(e.nm, "ghr", 32'(ghr1), 32'(e.ghr));
               cmp(e.nm, "cnt", cnt1, e.cnt);
            end else begin
               cmp(e.nm, "hit", 32'(hit0), 32'(e.hit));
               cmp(e.nm, "taken", 32'(taken0), 32'(e.taken));
               cmp(e.nm, "target", 32'(tgt0), 32'(e.tgt));
               cmp(e.nm, "ghr", 32'(ghr0), 32'(e.ghr));
               cmp(e.nm, "cnt", cnt0, e.cnt);
            end
         end
      end
   end

   task automatic push(input string nm, input bit sel, input bit hit, input bit taken,
                       input logic [11:0] tgt, input logic [5:0] ghr, input logic [31:0] cnt);
      exp_t x;
      x.nm = nm; x.sel = sel; x.hit = hit; x.taken = taken;
      x.tgt = tgt; x.ghr = ghr; x.cnt = cnt;
      expQ.push_back(x);
   endtask

   // One cycle of stimulus, driven 1 time unit after the posedge.
   task automatic step(input string nm, input bit lv, input logic [11:0] lpc,
                       input bit uv, input logic [11:0] upc, input logic [5:0] ughr,
                       input bit ut, input logic [11:0] utgt, input bit um,
                       input bit chk, input bit sel, input bit eHit, input bit eTaken,
                       input logic [11:0] eTgt, input logic [5:0] eGhr, input logic [31:0] eCnt);
      LOOKUP_VALID = lv;  LOOKUP_PC  = lpc;
      UPD_VALID    = uv;  UPD_PC     = upc;  UPD_GHR     = ughr;
      UPD_TAKEN    = ut;  UPD_TARGET = utgt; UPD_MISPRED = um;
      if (chk) begin
         push(nm, sel, eHit, eTaken, eTgt, eGhr, eCnt);
         chkEn = 1'b1;
      end
      @(posedge CLK);
      #1;
      chkEn = 1'b0;
      LOOKUP_VALID = 1'b0; UPD_VALID = 1'b0; UPD_MISPRED = 1'b0;
   endtask

   task automatic upd(input logic [11:0] pc, input logic [5:0] ghr, input bit taken,
                      input logic [11:0] tgt);
      step("upd", 1'b0, 12'h000, 1'b1, pc, ghr, taken, tgt, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 6'd0, 32'd0);
   endtask

   task automatic look(input string nm, input bit sel, input bit lv, input logic [11:0] pc,
                       input bit eHit, input bit eTaken, input logic [11:0] eTgt,
                       input logic [5:0] eGhr, input logic [31:0] eCnt);
      step(nm, lv, pc, 1'b0, 12'h000, 6'd0, 1'b0, 12'h000, 1'b0,
           1'b1, sel, eHit, eTaken, eTgt, eGhr, eCnt);
   endtask

   task automatic doReset();
      RSTn = 1'b0;
      @(posedge CLK);
      #1;
      RSTn = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      nCmp = 0; nFail = 0; chkEn = 1'b0;
      RSTn = 1'b0;
      LOOKUP_VALID = 1'b0; LOOKUP_PC = '0;
      UPD_VALID = 1'b0; UPD_PC = '0; UPD_GHR = '0;
      UPD_TAKEN = 1'b0; UPD_TARGET = '0; UPD_MISPRED = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RSTn = 1'b1;

      // Bimodal instance.
      look("t1_reset", 0, 0, 12'h040, 0, 0, 12'h000, 6'd0, 32'd0);
      upd(12'h040, 6'd0, 1, 12'h010);
      look("t2_first", 0, 0, 12'h040, 1, 1, 12'h010, 6'd0, 32'd0);
      repeat (4) upd(12'h040, 6'd0, 1, 12'h010);
      look("t3_sat", 0, 0, 12'h040, 1, 1, 12'h010, 6'd0, 32'd0);
      upd(12'h040, 6'd0, 0, 12'h000);
      look("t3_dec1", 0, 0, 12'h040, 1, 1, 12'h010, 6'd0, 32'd0);
      upd(12'h040, 6'd0, 0, 12'h000);
      look("t3_dec2", 0, 0, 12'h040, 1, 0, 12'h010, 6'd0, 32'd0);
      // Same-cycle lookup and taken update: old counter (01) is seen.
      step("t6_rdw", 0, 12'h040, 1, 12'h040, 6'd0, 1, 12'h010, 0,
           1, 0, 1, 0, 12'h010, 6'd0, 32'd0);
      look("t6_after", 0, 0, 12'h040, 1, 1, 12'h010, 6'd0, 32'd0);
      look("t4_alias", 0, 0, 12'h140, 0, 0, 12'h000, 6'd0, 32'd0);
      upd(12'h140, 6'd0, 1, 12'h200);
      look("t4_evicted", 0, 0, 12'h040, 0, 0, 12'h000, 6'd0, 32'd0);
      look("t4_new", 0, 0, 12'h140, 1, 1, 12'h200, 6'd0, 32'd0);
      // Mispredict flag without UPD_VALID must do nothing.
      step("ign_mispred", 0, 12'h140, 0, 12'h140, 6'h3f, 0, 12'h000, 1,
           1, 0, 1, 1, 12'h200, 6'd0, 32'd0);

      // Gshare instance.
      doReset();
      upd(12'h040, 6'd0, 1, 12'h010);
      upd(12'h040, 6'd1, 1, 12'h010);
      upd(12'h040, 6'd3, 1, 12'h010);
      look("t5_l1", 1, 1, 12'h040, 1, 1, 12'h010, 6'd0, 32'd0);
      look("t5_l2", 1, 1, 12'h040, 1, 1, 12'h010, 6'd1, 32'd0);
      look("t5_l3", 1, 1, 12'h040, 1, 1, 12'h010, 6'd3, 32'd0);
      step("t5_l4_repair", 1, 12'h040, 1, 12'h040, 6'b000010, 0, 12'h000, 1,
           1, 1, 1, 0, 12'h010, 6'b000111, 32'd0);
      look("t5_repaired", 1, 0, 12'h040, 1, 0, 12'h010, 6'b000100, 32'd1);
      step("t5_miss_noshift", 1, 12'h140, 0, 12'h000, 6'h3f, 1, 12'h000, 1,
           1, 1, 0, 0, 12'h000, 6'b000100, 32'd1);
      look("t5_nt_shift", 1, 1, 12'h040, 1, 0, 12'h010, 6'b000100, 32'd1);
      look("t5_ghr8", 1, 0, 12'h040, 1, 0, 12'h010, 6'b001000, 32'd1);

      // Asynchronous reset mid-cycle with live state.
      LOOKUP_PC = 12'h040;
      RSTn = 1'b0;
      #1;
      push("t1_async_rst", 1, 0, 0, 12'h000, 6'd0, 32'd0);
      chkEn = 1'b1;
      @(posedge CLK);
      #1;
      chkEn = 1'b0;
      RSTn = 1'b1;

      cmp("scoreboard", "pending", 32'(expQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
